// File: rtl/itch_feed_encoder.sv
`timescale 1ns/1ps
// itch_feed_encoder
// Serializes order-book events into the 64-bit ITCH-style beat stream that
// the market data processor consumes.
//
// Each message is a header beat followed by a body beat:
//   HDR  : data_type = 'A'/'E'/'X'/'D', data_in = {symbol, price}
//   BODY : data_type = CONT_TYPE,      data_in = {volume, side, 0.., seq}
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ev_valid/ev_ready     event handshake (ev_ready = FIFO not full)
//   ev_action             0=add 1=execute 2=cancel 3=delete, 4-7 dropped
//   ev_symbol/price/volume/side  event fields
//   data_valid/data_ready output beat handshake
//   data_in/data_type     output beat payload and type code
//   msgs_sent             completed messages (wraps at 2^32)
//   events_dropped        invalid-action events discarded (wraps at 2^32)
//   fifo_level            current event FIFO occupancy
//
// Optional build macro ITCH_TIMESTAMP_WORD_EN: adds a free-running 64-bit
// cycle counter, stores its value with each accepted event and appends a
// third 'T' (8'h54) beat carrying that timestamp.
module itch_feed_encoder #(
  parameter int         FIFO_DEPTH = 8,
  parameter int         SEQ_WIDTH  = 24,
  parameter logic [7:0] CONT_TYPE  = 8'h2B
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic [2:0]                    ev_action,
  input  logic [31:0]                   ev_symbol,
  input  logic [31:0]                   ev_price,
  input  logic [31:0]                   ev_volume,
  input  logic                          ev_side,
  output logic                          data_valid,
  output logic [63:0]                   data_in,
  output logic [7:0]                    data_type,
  input  logic                          data_ready,
  output logic [31:0]                   msgs_sent,
  output logic [31:0]                   events_dropped,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int BASE_W = 2 + 1 + 3 * 32;
`ifdef ITCH_TIMESTAMP_WORD_EN
  localparam int ENTRY_W = BASE_W + 64;
`else
  localparam int ENTRY_W = BASE_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_TS} state_t;

  state_t                 state_q, state_d;
  logic                   data_valid_q, data_valid_d;
  logic [63:0]            data_in_q, data_in_d;
  logic [7:0]             data_type_q, data_type_d;
  logic [31:0]            vol_q, vol_d;
  logic                   side_q, side_d;
  logic [SEQ_WIDTH-1:0]   seq_q, seq_d;
  logic [31:0]            msgs_q, msgs_d;
  logic [31:0]            dropped_q, dropped_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          count_q, count_d;

  logic                   accept, push, drop, pop, finish;
  logic [ENTRY_W-1:0]     wr_entry, head;
  logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];

`ifdef ITCH_TIMESTAMP_WORD_EN
  logic [63:0]            cycle_q, ts_q, ts_d;
`endif

  function automatic logic [7:0] action_code(input logic [1:0] a);
    case (a)
      2'd0:    action_code = 8'h41;
      2'd1:    action_code = 8'h45;
      2'd2:    action_code = 8'h58;
      default: action_code = 8'h44;
    endcase
  endfunction

  // Full flag comes only from registered occupancy, so a pop in the same
  // cycle never re-opens ev_ready until the following cycle.
  assign ev_ready = (count_q != LW'(FIFO_DEPTH));
  assign accept   = ev_valid && ev_ready;
  // Actions 4-7 complete the handshake but never reach the FIFO.
  assign push     = accept && !ev_action[2];
  assign drop     = accept && ev_action[2];

`ifdef ITCH_TIMESTAMP_WORD_EN
  assign wr_entry = {cycle_q, ev_action[1:0], ev_side, ev_volume, ev_price, ev_symbol};
`else
  assign wr_entry = {ev_action[1:0], ev_side, ev_volume, ev_price, ev_symbol};
`endif

  // Storage carries no reset: a reset flushes the FIFO through its pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  assign head = mem[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    data_valid_d = data_valid_q;
    data_in_d    = data_in_q;
    data_type_d  = data_type_q;
    vol_d        = vol_q;
    side_d       = side_q;
    seq_d        = seq_q;
    msgs_d       = msgs_q;
    dropped_d    = dropped_q;
    pop          = 1'b0;
    finish       = 1'b0;
`ifdef ITCH_TIMESTAMP_WORD_EN
    ts_d         = ts_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
        end
      end
      S_HDR: begin
        if (data_ready) begin
          state_d     = S_BODY;
          data_type_d = CONT_TYPE;
          // seq_q already holds this message's number: it only advances when
          // the previous message's final beat is accepted.
          data_in_d   = {vol_q, 32'(seq_q) | {side_q, 31'b0}};
        end
      end
      S_BODY: begin
        if (data_ready) begin
`ifdef ITCH_TIMESTAMP_WORD_EN
          state_d     = S_TS;
          data_type_d = 8'h54;
          data_in_d   = ts_q;
`else
          finish = 1'b1;
`endif
        end
      end
      default: begin
`ifdef ITCH_TIMESTAMP_WORD_EN
        if (data_ready) begin
          finish = 1'b1;
        end
`else
        state_d      = S_IDLE;
        data_valid_d = 1'b0;
`endif
      end
    endcase

    if (finish) begin
      msgs_d = msgs_q + 32'd1;
      seq_d  = seq_q + SEQ_WIDTH'(1);
      if (count_q != '0) begin
        pop = 1'b1;                 // chain straight into the next header
      end else begin
        state_d      = S_IDLE;
        data_valid_d = 1'b0;
      end
    end

    if (pop) begin
      state_d      = S_HDR;
      data_valid_d = 1'b1;
      data_type_d  = action_code(head[98:97]);
      data_in_d    = {head[31:0], head[63:32]};
      vol_d        = head[95:64];
      side_d       = head[96];
`ifdef ITCH_TIMESTAMP_WORD_EN
      ts_d         = head[162:99];
`endif
    end

    if (drop) begin
      dropped_d = dropped_q + 32'd1;
    end

    count_d  = count_q + LW'(push) - LW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      data_valid_q <= 1'b0;
      data_in_q    <= '0;
      data_type_q  <= '0;
      vol_q        <= '0;
      side_q       <= 1'b0;
      seq_q        <= '0;
      msgs_q       <= '0;
      dropped_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      data_valid_q <= data_valid_d;
      data_in_q    <= data_in_d;
      data_type_q  <= data_type_d;
      vol_q        <= vol_d;
      side_q       <= side_d;
      seq_q        <= seq_d;
      msgs_q       <= msgs_d;
      dropped_q    <= dropped_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

`ifdef ITCH_TIMESTAMP_WORD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      ts_q    <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      ts_q    <= ts_d;
    end
  end
`endif

  assign data_valid     = data_valid_q;
  assign data_in        = data_in_q;
  assign data_type      = data_type_q;
  assign msgs_sent      = msgs_q;
  assign events_dropped = dropped_q;
  assign fifo_level     = count_q;

endmodule

// File: tb/tb_itch_feed_encoder.sv
`timescale 1ns/1ps
module tb_itch_feed_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic [2:0]  ev_action = '0;
  logic [31:0] ev_symbol = '0;
  logic [31:0] ev_price = '0;
  logic [31:0] ev_volume = '0;
  logic        ev_side = 1'b0;
  logic        data_valid;
  logic [63:0] data_in;
  logic [7:0]  data_type;
  logic        data_ready = 1'b0;
  logic [31:0] msgs_sent;
  logic [31:0] events_dropped;
  logic [3:0]  fifo_level;

  int checks = 0;
  int failures = 0;
  logic [63:0] tb_cyc;

  itch_feed_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_action(ev_action),
    .ev_symbol(ev_symbol), .ev_price(ev_price), .ev_volume(ev_volume), .ev_side(ev_side),
    .data_valid(data_valid), .data_in(data_in), .data_type(data_type), .data_ready(data_ready),
    .msgs_sent(msgs_sent), .events_dropped(events_dropped), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Reference cycle count since reset release, for the timestamp beat.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 64'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ev_valid = 1'b0;
    data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_event(input logic [2:0] a, input logic [31:0] s, input logic [31:0] p,
                            input logic [31:0] v, input logic sd);
    ev_valid = 1'b1; ev_action = a; ev_symbol = s; ev_price = p; ev_volume = v; ev_side = sd;
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (data_valid === 1'b1) got = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_valid !== 1'b0 || data_type !== 8'h00 || data_in !== 64'h0 ||
        msgs_sent !== 32'd0 || events_dropped !== 32'd0 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%0b type=%h data=%h msgs=%0d drop=%0d lvl=%0d required all zero",
               data_valid, data_type, data_in, msgs_sent, events_dropped, fifo_level);
    end
    apply_reset();
    $display("test_reset done");
  endtask

  task automatic test_single_add();
    data_ready = 1'b1;
    send_event(3'd0, 32'h41415054, 32'h64000000, 32'd100, 1'b0);
    checks++;
    if (fifo_level !== 4'd1 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_n1: lvl=%0d valid=%0b required lvl=1 valid=0", fifo_level, data_valid);
    end
    tick();
    checks++;
    if (data_valid !== 1'b1 || data_type !== 8'h41 || data_in !== 64'h41415054_64000000) begin
      failures++;
      $display("FAIL add_hdr: valid=%0b type=%h data=%h required 1 41 4141505464000000",
               data_valid, data_type, data_in);
    end
    tick();
    checks++;
    if (data_valid !== 1'b1 || data_type !== 8'h2B || data_in !== {32'd100, 32'h0}) begin
      failures++;
      $display("FAIL add_body: valid=%0b type=%h data=%h required 1 2b %h",
               data_valid, data_type, data_in, {32'd100, 32'h0});
    end
    tick();
    checks++;
    if (data_valid !== 1'b0 || msgs_sent !== 32'd1) begin
      failures++;
      $display("FAIL add_done: valid=%0b msgs=%0d required 0 1", data_valid, msgs_sent);
    end
    $display("test_single_add done");
  endtask

  task automatic test_backpressure();
    data_ready = 1'b0;
    send_event(3'd1, 32'h4D534654, 32'h00001234, 32'd50, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (data_valid !== 1'b1 || data_type !== 8'h45 || data_in !== 64'h4D534654_00001234) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%0b type=%h data=%h required 1 45 4d53465400001234",
                 i, data_valid, data_type, data_in);
      end
      tick();
    end
    data_ready = 1'b1;
    tick();
    checks++;
    if (data_valid !== 1'b1 || data_type !== 8'h2B || data_in !== {32'd50, 32'h80000001}) begin
      failures++;
      $display("FAIL bp_body: valid=%0b type=%h data=%h required 1 2b %h",
               data_valid, data_type, data_in, {32'd50, 32'h80000001});
    end
    tick();
    checks++;
    if (data_valid !== 1'b0 || msgs_sent !== 32'd2) begin
      failures++;
      $display("FAIL bp_done: valid=%0b msgs=%0d required 0 2", data_valid, msgs_sent);
    end
    $display("test_backpressure done");
  endtask

  // With data_ready low the first event is popped into the output register,
  // so nine events are taken before the eight-entry FIFO reports full.
  task automatic test_fill_back_to_back();
    logic [7:0]  codes [4];
    logic [7:0]  et;
    logic [63:0] ed;
    int          accepted;
    int          m;
    logic [31:0] iv;
    codes[0] = 8'h41; codes[1] = 8'h45; codes[2] = 8'h58; codes[3] = 8'h44;
    apply_reset();
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      if (ev_ready !== 1'b1) break;
      iv = 32'(i);
      ev_valid = 1'b1; ev_action = 3'(i % 4); ev_symbol = 32'h53000000 + iv;
      ev_price = iv * 16; ev_volume = iv + 1; ev_side = iv[0];
      tick();
      accepted++;
    end
    ev_valid = 1'b0;
    checks++;
    if (accepted != 9 || ev_ready !== 1'b0 || fifo_level !== 4'd8) begin
      failures++;
      $display("FAIL fill_full: accepted=%0d ready=%0b lvl=%0d required 9 0 8",
               accepted, ev_ready, fifo_level);
    end
    data_ready = 1'b1;
    for (int b = 0; b < 18; b++) begin
      m  = b / 2;
      iv = 32'(m);
      if (b % 2 == 0) begin
        et = codes[m % 4];
        ed = {32'h53000000 + iv, iv * 16};
      end else begin
        et = 8'h2B;
        ed = {iv + 1, iv[0], 7'b0, 24'(m)};
      end
      checks++;
      if (data_valid !== 1'b1 || data_type !== et || data_in !== ed) begin
        failures++;
        $display("FAIL b2b_beat%0d: valid=%0b type=%h data=%h required 1 %h %h",
                 b, data_valid, data_type, data_in, et, ed);
      end
      tick();
    end
    checks++;
    if (data_valid !== 1'b0 || msgs_sent !== 32'd9 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL b2b_done: valid=%0b msgs=%0d lvl=%0d required 0 9 0",
               data_valid, msgs_sent, fifo_level);
    end
    $display("test_fill_back_to_back done");
  endtask

  task automatic test_drop();
    bit got;
    data_ready = 1'b1;
    send_event(3'd5, 32'h42414420, 32'd1, 32'd1, 1'b0);
    checks++;
    if (fifo_level !== 4'd0 || events_dropped !== 32'd1) begin
      failures++;
      $display("FAIL drop_count: lvl=%0d dropped=%0d required 0 1", fifo_level, events_dropped);
    end
    tick(); tick();
    checks++;
    if (data_valid !== 1'b0 || msgs_sent !== 32'd9) begin
      failures++;
      $display("FAIL drop_nobeat: valid=%0b msgs=%0d required 0 9", data_valid, msgs_sent);
    end
    send_event(3'd2, 32'h49424D20, 32'd7, 32'd3, 1'b0);
    wait_valid(got);
    checks++;
    if (!got || data_type !== 8'h58 || data_in !== {32'h49424D20, 32'd7}) begin
      failures++;
      $display("FAIL drop_cancel_hdr: got=%0b type=%h data=%h required 1 58 %h",
               got, data_type, data_in, {32'h49424D20, 32'd7});
    end
    tick();
    checks++;
    if (data_type !== 8'h2B || data_in !== {32'd3, 32'd9}) begin
      failures++;
      $display("FAIL drop_cancel_seq: type=%h data=%h required 2b %h", data_type, data_in, {32'd3, 32'd9});
    end
    tick();
    $display("test_drop done");
  endtask

  task automatic test_seq_wrap();
    bit got;
    logic [31:0] exp_low [2];
    exp_low[0] = 32'h00FFFFFF;
    exp_low[1] = 32'h00000000;
    data_ready = 1'b1;
    force dut.seq_q = 24'hFFFFFF;
    #1;
    release dut.seq_q;
    for (int k = 0; k < 2; k++) begin
      send_event(3'd0, 32'h57524150, 32'(k), 32'd9, 1'b0);
      wait_valid(got);
      tick();
      checks++;
      if (!got || data_type !== 8'h2B || data_in[31:0] !== exp_low[k]) begin
        failures++;
        $display("FAIL seq_wrap%0d: got=%0b type=%h low=%h required 1 2b %h",
                 k, got, data_type, data_in[31:0], exp_low[k]);
      end
      tick();
    end
    $display("test_seq_wrap done");
  endtask

  task automatic test_reset_mid_message();
    int beats;
    data_ready = 1'b0;
    send_event(3'd3, 32'h44454C20, 32'd5, 32'd6, 1'b1);
    send_event(3'd0, 32'h4E455854, 32'd8, 32'd9, 1'b0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    checks++;
    if (data_valid !== 1'b1 || data_type !== 8'h2B || fifo_level !== 4'd1) begin
      failures++;
      $display("FAIL rstmid_pre: valid=%0b type=%h lvl=%0d required 1 2b 1", data_valid, data_type, fifo_level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_valid !== 1'b0 || data_type !== 8'h00 || data_in !== 64'h0 ||
        fifo_level !== 4'd0 || msgs_sent !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_async: valid=%0b type=%h data=%h lvl=%0d msgs=%0d required all zero",
               data_valid, data_type, data_in, fifo_level, msgs_sent);
    end
    tick();
    rst_n = 1'b1;
    data_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (data_valid === 1'b1) beats++;
    end
    checks++;
    if (beats != 0) begin
      failures++;
      $display("FAIL rstmid_trailing: beats=%0d required 0", beats);
    end
    $display("test_reset_mid_message done");
  endtask

`ifdef ITCH_TIMESTAMP_WORD_EN
  task automatic test_timestamp();
    bit got;
    logic [63:0] acc;
    apply_reset();
    data_ready = 1'b1;
    tick(); tick();
    acc = tb_cyc;
    send_event(3'd0, 32'h41415054, 32'h64000000, 32'd100, 1'b0);
    wait_valid(got);
    tick();
    tick();
    checks++;
    if (!got || data_type !== 8'h54 || data_in !== acc) begin
      failures++;
      $display("FAIL ts_beat: got=%0b type=%h data=%h required 1 54 %h", got, data_type, data_in, acc);
    end
    tick();
    checks++;
    if (data_valid !== 1'b0 || msgs_sent !== 32'd1) begin
      failures++;
      $display("FAIL ts_done: valid=%0b msgs=%0d required 0 1", data_valid, msgs_sent);
    end
    $display("test_timestamp done");
  endtask
`endif

  initial begin
    test_reset();
`ifdef ITCH_TIMESTAMP_WORD_EN
    test_timestamp();
`else
    test_single_add();
    test_backpressure();
    test_fill_back_to_back();
    test_drop();
    test_seq_wrap();
    test_reset_mid_message();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
